spio_hss_multiplexer_chan_scheduler: RTL

- Sequences the frame-assembly datapath of the high-speed serial multiplexer.
- Round-robin arbitration across the 8 packet channels, gated by remote channel flow control and frame credit.
- Decides which channel's packet goes next, when a frame is full, and when a partly-filled frame must be flushed after inactivity.
- Sits between the per-channel input FIFOs and the frame assembler datapath.

---
 rtl/spio_hss_multiplexer_chan_scheduler_pkg.sv | 25 ++
 rtl/spio_hss_multiplexer_rr_arbiter.sv | 38 +++
 rtl/spio_hss_multiplexer_chan_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spio_hss_multiplexer_chan_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spio_hss_multiplexer_chan_scheduler_pkg
// Purpose : Shared constants and state encoding for the high-speed serial
//           multiplexer channel scheduler and its round-robin arbiter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package spio_hss_multiplexer_chan_scheduler_pkg;

   localparam int NUM_CHANS    = 8;
   localparam int CHAN_BITS    = $clog2(NUM_CHANS);
   localparam int PKTS_PER_FRM = 8;
   localparam int MAX_CRDT     = 32;
   localparam int CRDT_BITS    = $clog2(MAX_CRDT + 1);
   localparam int FRM_TMO      = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/spio_hss_multiplexer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spio_hss_multiplexer_rr_arbiter
// Purpose : Combinational rotate-priority encoder. Returns the first set bit
//           of elig at or after ptr, wrapping around.
// Ports   : elig  - request vector (NUM_REQ bits, power of 2)
//           ptr   - highest-priority index
//           idx   - selected index (valid when found)
//           found - at least one request set
// Revision: 1.0 - initial release
// ============================================================================
module spio_hss_multiplexer_rr_arbiter
   import spio_hss_multiplexer_chan_scheduler_pkg::*;
#(
   parameter int NUM_REQ = NUM_CHANS
) (
   input  logic [NUM_REQ-1:0]         elig,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       found
);

   localparam int IDX_BITS = $clog2(NUM_REQ);

   // NUM_REQ is a power of two, so truncating ptr+i gives the wrap for free.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && elig[IDX_BITS'(ptr + IDX_BITS'(i))]) begin
            found = 1'b1;
            idx   = IDX_BITS'(ptr + IDX_BITS'(i));
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spio_hss_multiplexer_chan_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : spio_hss_multiplexer_chan_scheduler
// Purpose : Frame-assembly sequencer. Round-robin picks the next packet
//           channel (gated by remote flow control and frame credit), marks
//           the packet that fills a frame, and flushes a partial frame after
//           FRM_TMO idle cycles.
// Ports   : clk, rst (sync, active-low)
//           chan_req/cfc_rem        - per-channel FIFO non-empty / remote stop
//           sel_vld/sel_chan/sel_last/sel_rdy - packet selection handshake
//           flush_vld/flush_rdy     - partial-frame flush handshake
//           crdt_ret_vld/crdt_ret_num - returned frame credits
//           reg_crdt/reg_ooc        - current credit / out-of-credit flag
// Revision: 1.0 - initial release
// ============================================================================
module spio_hss_multiplexer_chan_scheduler #(
   parameter int NUM_CHANS    = spio_hss_multiplexer_chan_scheduler_pkg::NUM_CHANS,
   parameter int PKTS_PER_FRM = spio_hss_multiplexer_chan_scheduler_pkg::PKTS_PER_FRM,
   parameter int MAX_CRDT     = spio_hss_multiplexer_chan_scheduler_pkg::MAX_CRDT,
   parameter int FRM_TMO      = spio_hss_multiplexer_chan_scheduler_pkg::FRM_TMO
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CHANS-1:0]          chan_req,
   input  logic [NUM_CHANS-1:0]          cfc_rem,
   output logic                          sel_vld,
   output logic [$clog2(NUM_CHANS)-1:0]  sel_chan,
   output logic                          sel_last,
   input  logic                          sel_rdy,
   output logic                          flush_vld,
   input  logic                          flush_rdy,
   input  logic                          crdt_ret_vld,
   input  logic [$clog2(MAX_CRDT+1)-1:0] crdt_ret_num,
   output logic [$clog2(MAX_CRDT+1)-1:0] reg_crdt,
   output logic                          reg_ooc
);

   import spio_hss_multiplexer_chan_scheduler_pkg::*;

   localparam int CH_W = $clog2(NUM_CHANS);
   localparam int CR_W = $clog2(MAX_CRDT + 1);
   localparam int FC_W = $clog2(PKTS_PER_FRM) + 1;
   localparam int TM_W = $clog2(FRM_TMO) + 1;

   sched_state_t    state_q, state_d;
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [FC_W-1:0] frm_cnt_q, frm_cnt_d;
   logic [TM_W-1:0] tmr_q, tmr_d;
   logic            sel_vld_q, sel_vld_d;
   logic [CH_W-1:0] sel_chan_q, sel_chan_d;
   logic            sel_last_q, sel_last_d;
   logic            flush_vld_q, flush_vld_d;
   logic [CR_W-1:0] crdt_q, crdt_d;
   logic            ooc_q, ooc_d;

   logic                 hs;
   logic                 frm_open;
   logic [NUM_CHANS-1:0] mask;
   logic [NUM_CHANS-1:0] arb_elig;
   logic [CH_W-1:0]      arb_idx;
   logic                 arb_found;
   logic [CR_W:0]        crdt_sum;

   assign hs = sel_vld_q & sel_rdy;

   // Frame sequencing: state, round-robin pointer, packet count, idle timer.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      frm_cnt_d = frm_cnt_q;
      tmr_d     = tmr_q;
      frm_open  = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (hs) begin
               frm_open = 1'b1;
               // A one-packet frame is opened and closed by the same transfer.
               if (PKTS_PER_FRM > 1) begin
                  state_d   = FILL;
                  frm_cnt_d = FC_W'(1);
               end
            end
         end
         FILL: begin
            if (hs) begin
               tmr_d = '0;
               if (sel_last_q) begin
                  state_d   = IDLE;
                  frm_cnt_d = '0;
               end else begin
                  frm_cnt_d = FC_W'(frm_cnt_q + 1'b1);
               end
            end else if (!sel_vld_q) begin
               if (tmr_q == TM_W'(FRM_TMO - 1)) begin
                  state_d = FLUSH;
               end else begin
                  tmr_d = TM_W'(tmr_q + 1'b1);
               end
            end
         end
         FLUSH: begin
            if (flush_rdy) begin
               state_d   = IDLE;
               frm_cnt_d = '0;
               tmr_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (hs) begin
         ptr_d = CH_W'(sel_chan_q + 1'b1);
      end
   end

   // The channel being handed over this cycle is excluded from the selection
   // registered at the same edge: its FIFO empty flag has not caught up yet.
   assign mask     = hs ? (NUM_CHANS'(1) << sel_chan_q) : '0;
   assign arb_elig = chan_req & ~cfc_rem & ~mask;

   spio_hss_multiplexer_rr_arbiter #(
      .NUM_REQ (NUM_CHANS)
   ) u_rr_arbiter (
      .elig  (arb_elig),
      .ptr   (ptr_d),
      .idx   (arb_idx),
      .found (arb_found)
   );

   // Offer register and credit accounting.
   always_comb begin
      sel_vld_d  = sel_vld_q;
      sel_chan_d = sel_chan_q;
      sel_last_d = sel_last_q;
      // An offer is frozen until it is taken; otherwise re-arbitrate.
      if (!sel_vld_q || sel_rdy) begin
         sel_vld_d = arb_found &&
                     ((state_d == FILL) ||
                      ((state_d == IDLE) && (crdt_q > CR_W'(frm_open))));
         if (sel_vld_d) begin
            sel_chan_d = arb_idx;
         end
         sel_last_d = (frm_cnt_d == FC_W'(PKTS_PER_FRM - 1));
      end
      flush_vld_d = (state_d == FLUSH);

      crdt_sum = {1'b0, crdt_q} - (CR_W+1)'(frm_open) +
                 (crdt_ret_vld ? {1'b0, crdt_ret_num} : '0);
      crdt_d   = (crdt_sum > (CR_W+1)'(MAX_CRDT)) ? CR_W'(MAX_CRDT)
                                                 : crdt_sum[CR_W-1:0];
      ooc_d    = (crdt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         frm_cnt_q   <= '0;
         tmr_q       <= '0;
         sel_vld_q   <= 1'b0;
         sel_chan_q  <= '0;
         sel_last_q  <= 1'b0;
         flush_vld_q <= 1'b0;
         crdt_q      <= CR_W'(MAX_CRDT);
         ooc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         frm_cnt_q   <= frm_cnt_d;
         tmr_q       <= tmr_d;
         sel_vld_q   <= sel_vld_d;
         sel_chan_q  <= sel_chan_d;
         sel_last_q  <= sel_last_d;
         flush_vld_q <= flush_vld_d;
         crdt_q      <= crdt_d;
         ooc_q       <= ooc_d;
      end
   end

   assign sel_vld   = sel_vld_q;
   assign sel_chan  = sel_chan_q;
   assign sel_last  = sel_last_q;
   assign flush_vld = flush_vld_q;
   assign reg_crdt  = crdt_q;
   assign reg_ooc   = ooc_q;

endmodule
`default_nettype wire
